kypd_scan_ctrl: RTL

Scanning controller for the Pmod KYPD 4x4 keypad on the Basys 3. It sequences the column drive lines and synchronises and samples the row lines. It debounces over whole scans and issues a clean one-key-at-a-time event interface. It replaces free-running ad-hoc decode: downstream logic (7-segment control, entry FSMs) consumes key_code/key_valid and the single-cycle press/release strobes.

---
 rtl/kypd_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/kypd_scan_ctrl.sv
// kypd_scan_ctrl: column scanner for the Pmod KYPD 4x4 keypad. Drives one
// active-low column at a time, samples synchronised rows, debounces over
// whole scans and reports one key at a time with press/release strobes.
//
// state  | meaning
// IDLE   | scanning off, all columns released
// SETTLE | column k driven, waiting for the row lines to settle
// SAMPLE | column k still driven, synchronised rows OR'd into scan result
// EVAL   | columns released, scan classified and debounced, commit decided
module kypd_scan_ctrl #(
  parameter int SETTLE_CYCLES  = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release,
  output logic       scan_busy
);

  // The settle counter only has to hold SETTLE_CYCLES-1.
  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);
  localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_EVAL   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    R_NONE  = 2'd0,
    R_KEY   = 2'd1,
    R_MULTI = 2'd2
  } res_t;

  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       rows_m_q, rows_s_q;

  // acc_q[k] holds the pressed rows seen on column k; bit 3 is the top row.
  logic [3:0][3:0]  acc_q, acc_d;

  res_t             cand_kind_q, cand_kind_d;
  logic [3:0]       cand_code_q, cand_code_d;
  logic [STB_W-1:0] stable_q, stable_d;

  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  res_t             res_kind;
  logic [3:0]       res_code;
  logic [4:0]       key_cnt;
  logic [3:0]       col_any;
  logic [3:0]       row_any;

  function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] k);
    logic [3:0] c;
    case ({r, k})
      4'b0000: c = 4'h1;
      4'b0001: c = 4'h2;
      4'b0010: c = 4'h3;
      4'b0011: c = 4'hA;
      4'b0100: c = 4'h4;
      4'b0101: c = 4'h5;
      4'b0110: c = 4'h6;
      4'b0111: c = 4'hB;
      4'b1000: c = 4'h7;
      4'b1001: c = 4'h8;
      4'b1010: c = 4'h9;
      4'b1011: c = 4'hC;
      4'b1100: c = 4'h0;
      4'b1101: c = 4'hF;
      4'b1110: c = 4'hE;
      default: c = 4'hD;
    endcase
    return c;
  endfunction

  // Only meaningful for a one-hot input; anything else encodes to 0.
  function automatic logic [1:0] oh_enc(input logic [3:0] oh);
    logic [1:0] p;
    case (oh)
      4'b0010: p = 2'd1;
      4'b0100: p = 2'd2;
      4'b1000: p = 2'd3;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

  // Two-flop synchroniser for the asynchronous row lines (idle high).
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      rows_m_q <= 4'b1111;
      rows_s_q <= 4'b1111;
    end else begin
      rows_m_q <= rows;
      rows_s_q <= rows_m_q;
    end
  end

  // FSM state register with column index and settle down-counter.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; dropping scan_en aborts to IDLE from any state.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (scan_en) begin
          state_d = S_SETTLE;
          col_d   = 2'd0;
          cnt_d   = CNT_LOAD;
        end
      end
      S_SETTLE: begin
        if (!scan_en) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SAMPLE: begin
        if (!scan_en) begin
          state_d = S_IDLE;
        end else if (col_q == 2'd3) begin
          state_d = S_EVAL;
        end else begin
          state_d = S_SETTLE;
          col_d   = col_q + 1'b1;
          cnt_d   = CNT_LOAD;
        end
      end
      default: begin
        if (!scan_en) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SETTLE;
          col_d   = 2'd0;
          cnt_d   = CNT_LOAD;
        end
      end
    endcase
  end

  // Column drive and busy flag decoded from the current state.
  always_comb begin
    cols      = 4'b1111;
    scan_busy = (state_q != S_IDLE);
    if (state_q == S_SETTLE || state_q == S_SAMPLE) begin
      cols = ~(4'b1000 >> col_q);
    end
  end

  // Scan accumulator: cleared between scans, OR'd with pressed rows on SAMPLE.
  always_comb begin
    acc_d = acc_q;
    if (state_q == S_IDLE || state_q == S_EVAL) begin
      acc_d = '0;
    end else if (state_q == S_SAMPLE && scan_en) begin
      acc_d[col_q] = acc_q[col_q] | ~rows_s_q;
    end
  end

  // Classify the finished scan; a single key is located by its row and column.
  always_comb begin
    key_cnt  = 5'($countones(acc_q));
    col_any  = {|acc_q[3], |acc_q[2], |acc_q[1], |acc_q[0]};
    row_any  = acc_q[0] | acc_q[1] | acc_q[2] | acc_q[3];
    res_kind = R_MULTI;
    res_code = 4'h0;
    if (key_cnt == 5'd0) begin
      res_kind = R_NONE;
    end else if (key_cnt == 5'd1) begin
      res_kind = R_KEY;
      res_code = key_lut(~oh_enc(row_any), oh_enc(col_any));
    end
  end

  // Debounce and commit; outputs change on the cycle after EVAL.
  always_comb begin
    cand_kind_d = cand_kind_q;
    cand_code_d = cand_code_q;
    stable_d    = stable_q;
    code_d      = code_q;
    valid_d     = valid_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    if (state_q != S_IDLE && !scan_en) begin
      cand_kind_d = R_NONE;
      cand_code_d = 4'h0;
      stable_d    = '0;
    end else if (state_q == S_EVAL) begin
      if (res_kind == cand_kind_q && (res_kind != R_KEY || res_code == cand_code_q)) begin
        if (stable_q != STB_MAX) begin
          stable_d = stable_q + 1'b1;
        end
      end else begin
        cand_kind_d = res_kind;
        cand_code_d = res_code;
        stable_d    = STB_ONE;
      end
      if (stable_d == STB_MAX) begin
        if (cand_kind_d == R_NONE && valid_q) begin
          valid_d   = 1'b0;
          release_d = 1'b1;
        end else if (cand_kind_d == R_KEY && (!valid_q || code_q != cand_code_d)) begin
          release_d = valid_q;
          press_d   = 1'b1;
          valid_d   = 1'b1;
          code_d    = cand_code_d;
        end
      end
    end
  end

  // Scan result, debounce and committed key registers.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      cand_kind_q <= R_NONE;
      cand_code_q <= 4'h0;
      stable_q    <= '0;
      code_q      <= 4'h0;
      valid_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cand_kind_q <= cand_kind_d;
      cand_code_q <= cand_code_d;
      stable_q    <= stable_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule
